cv32e40px_xif_copro_responder: RTL

- Coprocessor-side endpoint of the CORE-V-XIF issue/commit/result interfaces for cv32e40px; the core is the initiator.
- Decodes custom-0 instructions, buffers accepted ones in issue order and waits for commit or kill.
- Executes committed entries on a multi-cycle datapath and returns in-order results with register writeback.
- Compressed interface always rejects.

---
 rtl/cv32e40px_core_v_xif_pkg.sv | 54 +++++
 rtl/cv32e40px_xif_copro_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF type definitions shared by the cv32e40px core and its coprocessors.
// Field widths follow the 32-bit core with a 4-bit instruction id.
package cv32e40px_core_v_xif_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned X_NUM_RS    = 6;
    localparam int unsigned X_RFR_WIDTH = 32;
    localparam int unsigned X_RFW_WIDTH = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                            instr;
        logic [1:0]                             mode;
        logic [X_ID_WIDTH-1:0]                  id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]   rs;
        logic [X_NUM_RS-1:0]                    rs_valid;
        logic [5:0]                             ecs;
        logic                                   ecs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic ecswrite;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic [5:0]             ecsdata;
        logic [2:0]             ecswe;
        logic                   exc;
        logic [5:0]             exccode;
        logic                   err;
        logic                   dbg;
    } x_result_t;

endpackage

// File: rtl/cv32e40px_xif_copro_responder.sv
// Custom-0 coprocessor endpoint: accepts MAC/ADD3/MAXU/ABSDIFF, buffers them in
// issue order until commit/kill, executes the head over LATENCY cycles and returns results in order.
module cv32e40px_xif_copro_responder
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2,
    parameter logic [6:0]  OPCODE  = 7'b0001011
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               x_compressed_valid_i,
    output logic               x_compressed_ready_o,
    output x_compressed_resp_t x_compressed_resp_o,
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  x_issue_req_t       x_issue_req_i,
    output x_issue_resp_t      x_issue_resp_o,
    input  logic               x_commit_valid_i,
    input  x_commit_t          x_commit_i,
    output logic               x_result_valid_o,
    input  logic               x_result_ready_i,
    output x_result_t          x_result_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    x_result_t       result_q, result_d;
    logic            result_valid_q, result_valid_d;

    logic [DEPTH-1:0]      valid_q, committed_q, killed_q;
    logic [DEPTH-1:0]      valid_d, committed_d, killed_d;
    logic [DEPTH-1:0]      commit_hit;
    logic [X_ID_WIDTH-1:0] id_q  [DEPTH];
    logic [4:0]            rd_q  [DEPTH];
    logic [1:0]            op_q  [DEPTH];
    logic [XLEN-1:0]       rs1_q [DEPTH];
    logic [XLEN-1:0]       rs2_q [DEPTH];
    logic [XLEN-1:0]       rs3_q [DEPTH];
    logic [PW:0]           head_q, tail_q;
    logic [PW-1:0]         head_idx, tail_idx;

    logic [31:0]     instr;
    logic            dec_match, rs_ok, full, issue_fire, commit_new, pop;
    logic [XLEN-1:0] op_a, op_b, op_c, exec_data;
    logic            unused_inputs;

    assign instr     = x_issue_req_i.instr;
    assign dec_match = (instr[6:0] == OPCODE) && (instr[31:25] == 7'd0) && !instr[14];
    // rs3 only feeds MAC and ADD3 (funct3[1] == 0)
    assign rs_ok     = x_issue_req_i.rs_valid[0] && x_issue_req_i.rs_valid[1] &&
                       (instr[13] || x_issue_req_i.rs_valid[2]);

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign full     = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);

    assign x_issue_ready_o = dec_match ? (!full && rs_ok) : 1'b1;
    assign issue_fire      = x_issue_valid_i && x_issue_ready_o && dec_match;
    assign commit_new      = x_commit_valid_i && issue_fire && (x_commit_i.id == x_issue_req_i.id);

    always_comb begin
        x_issue_resp_o           = '0;
        x_issue_resp_o.accept    = dec_match;
        x_issue_resp_o.writeback = dec_match;
    end

    assign x_compressed_ready_o = 1'b1;
    assign x_compressed_resp_o  = '0;
    assign unused_inputs        = ^{x_compressed_valid_i, x_issue_req_i};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic is_head, is_tail;
        assign is_head         = pop && (head_idx == PW'(gi));
        assign is_tail         = issue_fire && (tail_idx == PW'(gi));
        assign commit_hit[gi]  = x_commit_valid_i && valid_q[gi] && !committed_q[gi] &&
                                 (id_q[gi] == x_commit_i.id);
        assign valid_d[gi]     = is_tail | (valid_q[gi] & ~is_head);
        assign committed_d[gi] = is_tail ? commit_new : (committed_q[gi] | commit_hit[gi]);
        assign killed_d[gi]    = is_tail ? (commit_new & x_commit_i.commit_kill)
                                         : (commit_hit[gi] ? x_commit_i.commit_kill : killed_q[gi]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
            if (pop)        head_q <= head_q + (PW+1)'(1);
            if (issue_fire) tail_q <= tail_q + (PW+1)'(1);
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            id_q[tail_idx]  <= x_issue_req_i.id;
            rd_q[tail_idx]  <= instr[11:7];
            op_q[tail_idx]  <= instr[13:12];
            rs1_q[tail_idx] <= x_issue_req_i.rs[0];
            rs2_q[tail_idx] <= x_issue_req_i.rs[1];
            rs3_q[tail_idx] <= x_issue_req_i.rs[2];
        end
    end

    assign op_a = rs1_q[head_idx];
    assign op_b = rs2_q[head_idx];
    assign op_c = rs3_q[head_idx];

    always_comb begin
        exec_data = '0;
        case (op_q[head_idx])
            2'd0:    exec_data = op_a * op_b + op_c;
            2'd1:    exec_data = op_a + op_b + op_c;
            2'd2:    exec_data = (op_a >= op_b) ? op_a : op_b;
            default: exec_data = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        pop            = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_q[head_idx] && committed_q[head_idx]) begin
                    if (killed_q[head_idx]) begin
                        pop = 1'b1;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d        = RESP;
                    result_valid_d = 1'b1;
                    result_d       = '0;
                    result_d.id    = id_q[head_idx];
                    result_d.data  = exec_data;
                    result_d.rd    = rd_q[head_idx];
                    result_d.we    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (x_result_ready_i) begin
                    pop            = 1'b1;
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_result_valid_o = result_valid_q;
    assign x_result_o       = result_q;

endmodule
